// File: rtl/cache_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_bus_pkg
// Brief   : Shared widths and responder state encoding for the cache line bus.
// Revision: 1.0 - initial release
// ============================================================================
package cache_bus_pkg;

    localparam int CB_DATA_WIDTH    = 64;
    localparam int CB_ADDR_WIDTH    = 64;
    localparam int CB_OFFSET_LENGTH = 4;
    localparam int CB_LINE_W        = CB_DATA_WIDTH * (2 ** CB_OFFSET_LENGTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_WR_DONE = 3'd4,
        ST_INV     = 3'd5
    } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/line_assembler.sv
`default_nettype none
// ============================================================================
// Module  : line_assembler
// Brief   : Line-wide register written one word at a time by index.
// Revision: 1.0 - initial release
// ============================================================================
module line_assembler #(
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      i_we,
    input  logic [OFFSET_LENGTH-1:0]                  i_idx,
    input  logic [DATA_WIDTH-1:0]                     i_wdata,
    output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  o_line
);

    localparam int LINE_W = DATA_WIDTH * (2 ** OFFSET_LENGTH);

    logic [LINE_W-1:0] r_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line <= '0;
        end else if (i_we) begin
            r_line[i_idx*DATA_WIDTH +: DATA_WIDTH] <= i_wdata;
        end
    end

    assign o_line = r_line;

endmodule
`default_nettype wire

// File: rtl/cache_line_responder.sv
`default_nettype none
// ============================================================================
// Module  : cache_line_responder
// Brief   : Serialises line fill/writeback commands into word memory requests.
// Revision: 1.0 - initial release
// ============================================================================
module cache_line_responder
    import cache_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = CB_DATA_WIDTH,
    parameter int ADDR_WIDTH    = CB_ADDR_WIDTH,
    parameter int OFFSET_LENGTH = CB_OFFSET_LENGTH
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      command_valid,
    input  logic                                      command_store,
    input  logic                                      command_rready,
    input  logic [ADDR_WIDTH-1:0]                     command_addr,
    input  logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  data_to_bus,
    output logic [DATA_WIDTH*(2**OFFSET_LENGTH)-1:0]  data_from_bus,
    output logic                                      bus_valid,
    output logic                                      bus_ready,
    output logic                                      invalidate,
    output logic [ADDR_WIDTH-1:0]                     invalidate_addr,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_ready,
    output logic                                      mem_req_write,
    output logic [ADDR_WIDTH-1:0]                     mem_req_addr,
    output logic [DATA_WIDTH-1:0]                     mem_req_wdata,
    input  logic                                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                     mem_resp_rdata,
    output logic                                      proto_err
);

    localparam int LINE_W  = DATA_WIDTH * (2 ** OFFSET_LENGTH);
    localparam int c_CNT_W = OFFSET_LENGTH + 1;
    localparam int c_HI_W  = ADDR_WIDTH - OFFSET_LENGTH;
    localparam logic [c_CNT_W-1:0] c_WORDS = c_CNT_W'(2 ** OFFSET_LENGTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'((2 ** OFFSET_LENGTH) - 1);

    resp_state_t         r_state;
    resp_state_t         w_state_nxt;

    logic [c_CNT_W-1:0]  r_req_cnt;
    logic [c_CNT_W-1:0]  r_rsp_cnt;
    logic [c_HI_W-1:0]   r_line_hi;
    logic [LINE_W-1:0]   r_wb_line;

    logic                r_req_valid;
    logic                r_req_write;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_wdata;
    logic                r_bus_valid;
    logic                r_bus_ready;
    logic                r_inv;
    logic [ADDR_WIDTH-1:0] r_inv_addr;
    logic                r_proto_err;

    logic                w_req_fire;
    logic [c_CNT_W-1:0]  w_req_cnt_inc;
    logic                w_rsp_expected;
    logic                w_rsp_store;
    logic                w_unused_ok;

    assign w_req_fire     = r_req_valid & mem_req_ready;
    assign w_req_cnt_inc  = r_req_cnt + c_CNT_W'(1);
    assign w_rsp_expected = (r_state == ST_READ) && (r_rsp_cnt < c_WORDS);
    assign w_rsp_store    = mem_resp_valid & w_rsp_expected;
    // Offset bits of the command address are discarded; rready is advisory only.
    assign w_unused_ok    = ^{command_rready, command_addr[OFFSET_LENGTH-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (command_valid) begin
                    w_state_nxt = command_store ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (w_rsp_store && (r_rsp_cnt == c_LAST)) begin
                    w_state_nxt = ST_RD_DONE;
                end
            end
            ST_RD_DONE: w_state_nxt = ST_IDLE;
            ST_WRITE: begin
                if (w_req_fire && (r_req_cnt == c_LAST)) begin
                    w_state_nxt = ST_WR_DONE;
                end
            end
            ST_WR_DONE: w_state_nxt = ST_INV;
            ST_INV:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_line_hi   <= '0;
            r_wb_line   <= '0;
            r_req_valid <= 1'b0;
            r_req_write <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_bus_valid <= 1'b0;
            r_bus_ready <= 1'b0;
            r_inv       <= 1'b0;
            r_inv_addr  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            // Pulses are decoded from the next state so they line up with it.
            r_bus_valid <= (w_state_nxt == ST_RD_DONE);
            r_bus_ready <= (w_state_nxt == ST_WR_DONE);
            r_inv       <= (w_state_nxt == ST_INV);

            if (r_state == ST_WR_DONE) begin
                r_inv_addr <= {r_line_hi, {OFFSET_LENGTH{1'b0}}};
            end

            if (mem_resp_valid && !w_rsp_expected) begin
                r_proto_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (command_valid) begin
                        r_line_hi   <= command_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
                        r_req_cnt   <= '0;
                        r_rsp_cnt   <= '0;
                        r_req_valid <= 1'b1;
                        r_req_write <= command_store;
                        r_req_addr  <= {command_addr[ADDR_WIDTH-1:OFFSET_LENGTH],
                                        {OFFSET_LENGTH{1'b0}}};
                        if (command_store) begin
                            r_wb_line   <= data_to_bus;
                            r_req_wdata <= data_to_bus[DATA_WIDTH-1:0];
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (w_req_fire) begin
                        r_req_cnt  <= w_req_cnt_inc;
                        r_req_addr <= {r_line_hi, w_req_cnt_inc[OFFSET_LENGTH-1:0]};
                        if (r_req_write) begin
                            r_req_wdata <= r_wb_line[w_req_cnt_inc[OFFSET_LENGTH-1:0]*DATA_WIDTH +: DATA_WIDTH];
                        end
                        if (w_req_cnt_inc == c_WORDS) begin
                            r_req_valid <= 1'b0;
                            r_req_write <= 1'b0;
                        end
                    end
                    if (w_rsp_store) begin
                        r_rsp_cnt <= r_rsp_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    line_assembler #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OFFSET_LENGTH (OFFSET_LENGTH)
    ) u_fill_line (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_rsp_store),
        .i_idx   (r_rsp_cnt[OFFSET_LENGTH-1:0]),
        .i_wdata (mem_resp_rdata),
        .o_line  (data_from_bus)
    );

    assign bus_valid       = r_bus_valid;
    assign bus_ready       = r_bus_ready;
    assign invalidate      = r_inv;
    assign invalidate_addr = r_inv_addr;
    assign mem_req_valid   = r_req_valid;
    assign mem_req_write   = r_req_write;
    assign mem_req_addr    = r_req_addr;
    assign mem_req_wdata   = r_req_wdata;
    assign proto_err       = r_proto_err;

endmodule
`default_nettype wire
